// File: rtl/mix_column_seq.sv
// rtl/mix_column_seq.sv - column-serial AES MixColumns engine with valid/ready handshakes
module mix_column_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter int DATA_WIDTH     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    if (DATA_WIDTH != 8) begin : g_bad_width
        $error("mix_column_seq: DATA_WIDTH must be 8");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] src_q, src_d;
    logic [127:0] out_q, out_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic         accept;
    logic         last_group;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    assign last_group = (int'(col_cnt_q) + COLS_PER_CYCLE) >= 4;

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        out_d     = out_q;
        col_cnt_d = col_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    src_d     = in_state;
                    col_cnt_d = 2'd0;
                    if (in_bypass) begin
                        out_d   = in_state;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Only the columns in the current group pass through the shared multipliers.
                for (int c = 0; c < 4; c++) begin
                    if (c >= int'(col_cnt_q) && c < int'(col_cnt_q) + COLS_PER_CYCLE) begin
                        out_d[127-32*c -: 32] = mix_col(src_q[127-32*c -: 32]);
                    end
                end
                if (last_group) begin
                    col_cnt_d = 2'd0;
                    state_d   = ST_DONE;
                end else begin
                    col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            out_q     <= '0;
            col_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            out_q     <= out_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign out_state = out_q;
    assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_mix_column_seq.sv
// tb/tb_mix_column_seq.sv - directed and randomized checks of mix_column_seq at 1, 2 and 4 columns per cycle
module tb_mix_column_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv[3], ir[3], ib[3], ov[3], orr[3], bz[3];
    logic [127:0] ist[3], os[3];
    int           checks = 0;
    int           failures = 0;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225cc6c6c6c6d4d4d4d5;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6;
    localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    mix_column_seq #(.COLS_PER_CYCLE(1), .DATA_WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
        .in_bypass(ib[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_state(os[0]), .busy(bz[0]));
    mix_column_seq #(.COLS_PER_CYCLE(2), .DATA_WIDTH(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
        .in_bypass(ib[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_state(os[1]), .busy(bz[1]));
    mix_column_seq #(.COLS_PER_CYCLE(4), .DATA_WIDTH(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
        .in_bypass(ib[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_state(os[2]), .busy(bz[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a[4];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int k = 0; k < 4; k++) begin
                r[127-32*c-8*k -: 8] = gmul(a[k], 8'h02) ^ gmul(a[(k+1)%4], 8'h03)
                                     ^ a[(k+2)%4] ^ a[(k+3)%4];
            end
        end
        return r;
    endfunction

    function automatic int exp_lat(input int i, input logic b);
        if (b) return 1;
        return (i == 0) ? 5 : (i == 1) ? 3 : 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [127:0] s, input logic b,
                        output int lat, output logic [127:0] res);
        int n;
        iv[i] = 1'b1; ist[i] = s; ib[i] = b;
        #1;
        n = 0;
        while (!ir[i] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ir[i] !== 1'b1) begin
            failures++;
            $display("FAIL send_accept_timeout dut=%0d in_ready=%b required=1", i, ir[i]);
        end
        tick();
        iv[i] = 1'b0;
        ist[i] = ~s;
        ib[i] = ~b;
        lat = 1;
        while (!ov[i] && lat < 20) begin
            tick();
            lat++;
        end
        res = os[i];
        orr[i] = 1'b1;
        tick();
        orr[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (ov[0] !== 1'b0 || os[0] !== 128'h0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got ov=%b os=%h ir=%b busy=%b required ov=0 os=0 ir=1 busy=0",
                     ov[0], os[0], ir[0], bz[0]);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        send(0, FIPS_IN, 1'b0, lat, res);
        checks++;
        if (res !== FIPS_OUT) begin
            failures++;
            $display("FAIL fips_result got %h required %h", res, FIPS_OUT);
        end
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL fips_latency got %0d required 5", lat);
        end
    endtask

    task automatic test_columns();
        int lat;
        logic [127:0] res;
        for (int i = 0; i < 3; i++) begin
            send(i, COL_IN, 1'b0, lat, res);
            checks++;
            if (res !== COL_OUT) begin
                failures++;
                $display("FAIL column_identities dut=%0d got %h required %h", i, res, COL_OUT);
            end
        end
    endtask

    task automatic test_bypass();
        int lat;
        logic [127:0] res;
        send(0, BYP_IN, 1'b1, lat, res);
        checks++;
        if (res !== BYP_IN || lat !== 1) begin
            failures++;
            $display("FAIL bypass got %h lat=%0d required %h lat=1", res, lat, BYP_IN);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int lat;
        logic [127:0] res;
        iv[0] = 1'b1; ist[0] = COL_IN; ib[0] = 1'b0;
        tick();
        ist[0] = FIPS_IN;
        n = 0;
        while (!ov[0] && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (os[0] !== COL_OUT || ov[0] !== 1'b1 || ir[0] !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold cycle=%0d got os=%h ov=%b ir=%b required os=%h ov=1 ir=0",
                         k, os[0], ov[0], ir[0], COL_OUT);
            end
            tick();
        end
        orr[0] = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_ready got in_ready=%b required 1", ir[0]);
        end
        tick();
        orr[0] = 1'b0;
        iv[0] = 1'b0;
        ist[0] = 128'h0;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_reaccept got ov=%b busy=%b required ov=0 busy=1", ov[0], bz[0]);
        end
        lat = 1;
        while (!ov[0] && lat < 20) begin
            tick();
            lat++;
        end
        res = os[0];
        checks++;
        if (res !== FIPS_OUT || lat !== 5) begin
            failures++;
            $display("FAIL backpressure_next got %h lat=%0d required %h lat=5", res, lat, FIPS_OUT);
        end
        orr[0] = 1'b1;
        tick();
        orr[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        orr[0] = 1'b1;
        iv[0] = 1'b1; ib[0] = 1'b1; ist[0] = BYP_IN;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || os[0] !== BYP_IN) begin
            failures++;
            $display("FAIL back_to_back_first got ov=%b os=%h required ov=1 os=%h", ov[0], os[0], BYP_IN);
        end
        ist[0] = FIPS_IN;
        tick();
        checks++;
        if (ov[0] !== 1'b1 || os[0] !== FIPS_IN) begin
            failures++;
            $display("FAIL back_to_back_second got ov=%b os=%h required ov=1 os=%h", ov[0], os[0], FIPS_IN);
        end
        iv[0] = 1'b0;
        tick();
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_drop got ov=%b busy=%b required ov=0 busy=0", ov[0], bz[0]);
        end
        orr[0] = 1'b0;
        ib[0] = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [127:0] res;
        iv[0] = 1'b1; ist[0] = COL_IN; ib[0] = 1'b0;
        tick();
        tick();
        iv[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov[0] !== 1'b0 || os[0] !== 128'h0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_calc got ov=%b os=%h ir=%b busy=%b required ov=0 os=0 ir=1 busy=0",
                     ov[0], os[0], ir[0], bz[0]);
        end
        rst_n = 1'b1;
        tick();
        send(0, FIPS_IN, 1'b0, lat, res);
        checks++;
        if (res !== FIPS_OUT || lat !== 5) begin
            failures++;
            $display("FAIL reset_recover got %h lat=%0d required %h lat=5", res, lat, FIPS_OUT);
        end
    endtask

    task automatic test_sweep();
        int lat;
        logic [127:0] s, res, expd;
        logic b;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 300; n++) begin
                s = {$urandom, $urandom, $urandom, $urandom};
                b = ($urandom_range(0, 7) == 0);
                expd = b ? s : ref_mix(s);
                send(i, s, b, lat, res);
                checks++;
                if (res !== expd || lat !== exp_lat(i, b)) begin
                    failures++;
                    $display("FAIL sweep dut=%0d n=%0d bypass=%b got %h lat=%0d required %h lat=%0d",
                             i, n, b, res, lat, expd, exp_lat(i, b));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ib[i] = 1'b0; orr[i] = 1'b0; ist[i] = '0;
        end
        test_reset();
        test_fips();
        test_columns();
        test_bypass();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_calc();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
